// File: rtl/program_loader.sv
// Boot-time program loader: receives a little-endian word count and instruction words
// over a UART byte stream, writes them to instruction memory, then reports status.
module program_loader #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter logic [7:0]  ACK_BYTE   = 8'hAA,
   parameter logic [7:0]  NACK_BYTE  = 8'hEE
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  loading,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {
      S_LEN,
      S_DATA,
      S_ACK,
      S_DONE,
      S_ERR
   } state_t;

   // One extra bit so a count of exactly 2**ADDR_WIDTH stays representable.
   localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

   state_t                r_state;
   state_t                w_state_next;
   logic [1:0]            r_byte_cnt;
   logic [ADDR_WIDTH-1:0] r_word_idx;
   logic [31:0]           r_len;
   logic [31:0]           r_shift;
   logic                  r_nack_sent;
   logic                  r_imem_we;
   logic [ADDR_WIDTH-1:0] r_imem_addr;
   logic [31:0]           r_imem_wdata;

   logic                  w_in_load;
   logic                  w_last_byte;
   logic [31:0]           w_len_next;
   logic [31:0]           w_shift_next;
   logic [31:0]           w_word_next;

   assign w_in_load    = (r_state == S_LEN) || (r_state == S_DATA);
   assign w_last_byte  = rx_valid && (r_byte_cnt == 2'd3);
   assign w_len_next   = {rx_data, r_len[31:8]};
   assign w_shift_next = {rx_data, r_shift[31:8]};
   assign w_word_next  = 32'(r_word_idx) + 32'd1;

   // NOTE: state and datapath registers use non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= S_LEN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // NOTE: every output and next-state signal gets a default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      w_state_next = r_state;
      tx_data      = 8'h00;
      tx_valid     = 1'b0;
      loading      = 1'b0;
      done         = 1'b0;
      error        = 1'b0;
      case (r_state)
         S_LEN: begin
            loading = (r_byte_cnt != 2'd0);
            if (w_last_byte) begin
               if ({1'b0, w_len_next} > CAPACITY) begin
                  w_state_next = S_ERR;
               end else if (w_len_next == 32'd0) begin
                  w_state_next = S_ACK;
               end else begin
                  w_state_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            loading = 1'b1;
            if (w_last_byte && (w_word_next == r_len)) begin
               w_state_next = S_ACK;
            end
         end
         S_ACK: begin
            loading  = 1'b1;
            tx_data  = ACK_BYTE;
            tx_valid = 1'b1;
            if (tx_ready) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
         end
         S_ERR: begin
            error    = 1'b1;
            tx_data  = NACK_BYTE;
            tx_valid = !r_nack_sent;
         end
         default: begin
            w_state_next = S_LEN;
         end
      endcase
   end

   // Byte assembly and the registered write port; a reset drops any pending write.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_byte_cnt   <= 2'd0;
         r_word_idx   <= '0;
         r_len        <= 32'd0;
         r_shift      <= 32'd0;
         r_nack_sent  <= 1'b0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= 32'd0;
      end else begin
         r_imem_we <= 1'b0;
         if (rx_valid && w_in_load) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
         end
         if (rx_valid && (r_state == S_LEN)) begin
            r_len <= w_len_next;
         end
         if (rx_valid && (r_state == S_DATA)) begin
            r_shift <= w_shift_next;
            if (r_byte_cnt == 2'd3) begin
               r_imem_we    <= 1'b1;
               r_imem_addr  <= r_word_idx;
               r_imem_wdata <= w_shift_next;
               r_word_idx   <= r_word_idx + 1'b1;
            end
         end
         if ((r_state == S_ERR) && tx_ready) begin
            r_nack_sent <= 1'b1;
         end
      end
   end

   assign imem_we    = r_imem_we;
   assign imem_addr  = r_imem_addr;
   assign imem_wdata = r_imem_wdata;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: expected memory writes are queued as bytes
// are driven and compared by a write monitor; status outputs are checked per scenario.
module tb_program_loader;

   localparam int unsigned AW = 12;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic          clk;
   logic          rstn;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          loading;
   logic          done;
   logic          error;

   wr_t exp_q[$];
   int  n_vectors;
   int  n_miscompares;

   program_loader #(
      .ADDR_WIDTH (AW),
      .ACK_BYTE   (8'hAA),
      .NACK_BYTE  (8'hEE)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .loading    (loading),
      .done       (done),
      .error      (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         n_vectors++;
         if (exp_q.size() == 0) begin
            n_miscompares++;
            $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", imem_addr, imem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if ({imem_addr, imem_wdata} !== {e.addr, e.data}) begin
               n_miscompares++;
               $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                        imem_addr, imem_wdata, e.addr, e.data);
            end
         end
      end
   end

   task automatic do_reset();
      rstn = 1'b0;
      rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   // Drives one byte for exactly one cycle; returns 1 time unit after the sampling edge.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) begin
         logic [31:0] t;
         t = w >> (8 * k);
         send_byte(t[7:0]);
      end
   endtask

   task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic test_queue_drained(input string name);
      n_vectors++;
      if (exp_q.size() !== 0) begin
         n_miscompares++;
         $display("FAIL %s_missing_writes: got %0d outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      tx_ready = 1'b1;
      do_reset();
      n_vectors++;
      if ({imem_we, imem_addr, imem_wdata, tx_data, tx_valid, loading, done, error} !== '0) begin
         n_miscompares++;
         $display("FAIL reset_outputs: got we=%b addr=%h wdata=%h tx=%h txv=%b ld=%b dn=%b er=%b, expected all 0",
                  imem_we, imem_addr, imem_wdata, tx_data, tx_valid, loading, done, error);
      end
   endtask

   task automatic test_len2();
      tx_ready = 1'b1;
      do_reset();
      send_byte(8'h02);
      n_vectors++;
      if (loading !== 1'b1) begin
         n_miscompares++;
         $display("FAIL len2_loading: got %b expected 1", loading);
      end
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      expect_write(12'h000, 32'h0000_0013);
      expect_write(12'h001, 32'h0050_00B3);
      send_word(32'h0000_0013);
      n_vectors++;
      if ({imem_we, imem_addr} !== {1'b1, 12'h000}) begin
         n_miscompares++;
         $display("FAIL len2_write_latency: got we=%b addr=%h expected we=1 addr=000", imem_we, imem_addr);
      end
      send_word(32'h0050_00B3);
      n_vectors++;
      if ({imem_we, tx_valid, tx_data} !== {1'b1, 1'b1, 8'hAA}) begin
         n_miscompares++;
         $display("FAIL len2_last_write_ack: got we=%b txv=%b tx=%h expected we=1 txv=1 tx=aa",
                  imem_we, tx_valid, tx_data);
      end
      @(posedge clk); #1;
      n_vectors++;
      if ({done, error, tx_valid, loading} !== 4'b1000) begin
         n_miscompares++;
         $display("FAIL len2_done: got dn=%b er=%b txv=%b ld=%b expected dn=1 er=0 txv=0 ld=0",
                  done, error, tx_valid, loading);
      end
      send_word(32'h1234_5678);
      repeat (2) @(posedge clk); #1;
      n_vectors++;
      if ({done, error, loading} !== 3'b100) begin
         n_miscompares++;
         $display("FAIL done_ignores_rx: got dn=%b er=%b ld=%b expected dn=1 er=0 ld=0", done, error, loading);
      end
      test_queue_drained("len2");
   endtask

   task automatic test_len0();
      tx_ready = 1'b1;
      do_reset();
      send_word(32'h0000_0000);
      n_vectors++;
      if ({imem_we, tx_valid, tx_data} !== {1'b0, 1'b1, 8'hAA}) begin
         n_miscompares++;
         $display("FAIL len0_ack: got we=%b txv=%b tx=%h expected we=0 txv=1 tx=aa", imem_we, tx_valid, tx_data);
      end
      @(posedge clk); #1;
      n_vectors++;
      if ({done, tx_valid} !== 2'b10) begin
         n_miscompares++;
         $display("FAIL len0_done: got dn=%b txv=%b expected dn=1 txv=0", done, tx_valid);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] lens [2];
      lens[0] = 32'h0000_1001;
      lens[1] = 32'h0001_0000;
      for (int i = 0; i < 2; i++) begin
         tx_ready = 1'b1;
         do_reset();
         send_word(lens[i]);
         n_vectors++;
         if ({error, tx_valid, tx_data, loading} !== {1'b1, 1'b1, 8'hEE, 1'b0}) begin
            n_miscompares++;
            $display("FAIL overflow_nack[%0d]: got er=%b txv=%b tx=%h ld=%b expected er=1 txv=1 tx=ee ld=0",
                     i, error, tx_valid, tx_data, loading);
         end
         @(posedge clk); #1;
         n_vectors++;
         if ({error, tx_valid} !== 2'b10) begin
            n_miscompares++;
            $display("FAIL overflow_handshake[%0d]: got er=%b txv=%b expected er=1 txv=0", i, error, tx_valid);
         end
         send_word(32'hDEAD_BEEF);
         send_word(32'h0000_0013);
         n_vectors++;
         if ({error, done, loading} !== 3'b100) begin
            n_miscompares++;
            $display("FAIL overflow_sticky[%0d]: got er=%b dn=%b ld=%b expected er=1 dn=0 ld=0",
                     i, error, done, loading);
         end
      end
   endtask

   task automatic test_full_capacity();
      tx_ready = 1'b1;
      do_reset();
      send_word(32'h0000_1000);
      for (int i = 0; i < 4096; i++) begin
         expect_write(AW'(i), 32'(i));
         send_word(32'(i));
      end
      n_vectors++;
      if ({imem_we, imem_addr, tx_valid, tx_data} !== {1'b1, 12'hFFF, 1'b1, 8'hAA}) begin
         n_miscompares++;
         $display("FAIL full_last_write: got we=%b addr=%h txv=%b tx=%h expected we=1 addr=fff txv=1 tx=aa",
                  imem_we, imem_addr, tx_valid, tx_data);
      end
      @(posedge clk); #1;
      n_vectors++;
      if ({done, error} !== 2'b10) begin
         n_miscompares++;
         $display("FAIL full_done: got dn=%b er=%b expected dn=1 er=0", done, error);
      end
      test_queue_drained("full");
   endtask

   task automatic test_backpressure();
      tx_ready = 1'b0;
      do_reset();
      send_word(32'h0000_0001);
      expect_write(12'h000, 32'hDEAD_BEEF);
      send_word(32'hDEAD_BEEF);
      for (int i = 0; i < 6; i++) begin
         n_vectors++;
         if ({tx_valid, tx_data, done, loading} !== {1'b1, 8'hAA, 1'b0, 1'b1}) begin
            n_miscompares++;
            $display("FAIL bp_hold[%0d]: got txv=%b tx=%h dn=%b ld=%b expected txv=1 tx=aa dn=0 ld=1",
                     i, tx_valid, tx_data, done, loading);
         end
         if (i == 5) tx_ready = 1'b1;
         @(posedge clk); #1;
      end
      n_vectors++;
      if ({done, tx_valid} !== 2'b10) begin
         n_miscompares++;
         $display("FAIL bp_done: got dn=%b txv=%b expected dn=1 txv=0", done, tx_valid);
      end
      test_queue_drained("bp");
   endtask

   task automatic test_reset_midload();
      tx_ready = 1'b1;
      do_reset();
      send_word(32'h0000_0001);
      send_byte(8'h11);
      send_byte(8'h22);
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      n_vectors++;
      if ({imem_we, imem_addr, imem_wdata, tx_data, tx_valid, loading, done, error} !== '0) begin
         n_miscompares++;
         $display("FAIL midload_reset: got we=%b addr=%h wdata=%h tx=%h txv=%b ld=%b dn=%b er=%b, expected all 0",
                  imem_we, imem_addr, imem_wdata, tx_data, tx_valid, loading, done, error);
      end
      send_word(32'h0000_0001);
      expect_write(12'h000, 32'h0000_0073);
      send_word(32'h0000_0073);
      n_vectors++;
      if ({imem_we, imem_addr, imem_wdata, tx_valid, tx_data} !== {1'b1, 12'h000, 32'h0000_0073, 1'b1, 8'hAA}) begin
         n_miscompares++;
         $display("FAIL midload_reload: got we=%b addr=%h wdata=%h txv=%b tx=%h expected we=1 addr=000 wdata=00000073 txv=1 tx=aa",
                  imem_we, imem_addr, imem_wdata, tx_valid, tx_data);
      end
      @(posedge clk); #1;
      n_vectors++;
      if (done !== 1'b1) begin
         n_miscompares++;
         $display("FAIL midload_done: got %b expected 1", done);
      end
      test_queue_drained("midload");
   endtask

   initial begin
      n_vectors     = 0;
      n_miscompares = 0;
      rstn          = 1'b0;
      rx_data       = 8'h00;
      rx_valid      = 1'b0;
      tx_ready      = 1'b1;
      test_reset();
      test_len2();
      test_len0();
      test_overflow();
      test_full_capacity();
      test_backpressure();
      test_reset_midload();
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
